// File: rtl/sampler_pkg.sv
// Shared types and constants for the keyboard sampler record/playback path:
// FSM states, key indices (q..o) and the 3-bit note codes they map to.
package sampler_pkg;

  localparam int NUM_KEYS = 9;

  typedef enum logic [1:0] {
    ST_LIVE = 2'd0,
    ST_REC1 = 2'd1,
    ST_REC2 = 2'd2,
    ST_PLAY = 2'd3
  } state_e;

  localparam logic [3:0] KEY_Q = 4'd0;
  localparam logic [3:0] KEY_W = 4'd1;
  localparam logic [3:0] KEY_E = 4'd2;
  localparam logic [3:0] KEY_R = 4'd3;
  localparam logic [3:0] KEY_T = 4'd4;
  localparam logic [3:0] KEY_Y = 4'd5;
  localparam logic [3:0] KEY_U = 4'd6;
  localparam logic [3:0] KEY_I = 4'd7;
  localparam logic [3:0] KEY_O = 4'd8;

  localparam logic [2:0] CODE_REST = 3'b000;
  localparam logic [2:0] CODE_Q    = 3'b001;
  localparam logic [2:0] CODE_W    = 3'b010;
  localparam logic [2:0] CODE_E    = 3'b100;
  localparam logic [2:0] CODE_R    = 3'b110;
  localparam logic [2:0] CODE_HIGH = 3'b011;

  function automatic logic [2:0] key_to_code(input logic [3:0] idx);
    case (idx)
      KEY_Q:                             return CODE_Q;
      KEY_W:                             return CODE_W;
      KEY_E:                             return CODE_E;
      KEY_R:                             return CODE_R;
      KEY_T, KEY_Y, KEY_U, KEY_I, KEY_O: return CODE_HIGH;
      default:                           return CODE_REST;
    endcase
  endfunction

endpackage

// File: rtl/tempo_tick.sv
// Playback tempo divider: emits a one-cycle tick every TICK_DIV enabled cycles,
// counted from the last restart. Holds its count while disabled.
module tempo_tick #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || i_restart) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (i_en) begin
      r_tick  <= w_wrap;
      r_count <= w_wrap ? '0 : r_count + 1'b1;
    end else begin
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/sampler_sequencer.sv
// Record/playback controller: live note output, recording into two key-index
// tracks, and tempo-driven playback with track 1 taking priority over track 2.
module sampler_sequencer
  import sampler_pkg::*;
#(
  parameter int STEPS    = 9,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [8:0] keys,
  input  logic [1:0] mode,
  input  logic [1:0] play,
  input  logic       clear,
  output logic [2:0] out_code,
  output logic [1:0] state_o,
  output logic [1:0] rec_full,
  output logic [3:0] step_idx
);

  localparam logic [3:0] FULL_LEN = 4'(STEPS);

  state_e     r_state, w_state_nxt;
  logic [8:0] r_keys_prev;
  logic [1:0] r_play;
  logic       r_play_start;
  logic [3:0] r_step;
  logic [2:0] r_code;
  logic [3:0] r_len [2];
  logic [3:0] r_mem [2][STEPS];

  logic       w_one_hot, w_event, w_enter_play, w_tick;
  logic [3:0] w_key_idx, w_bound, w_step_nxt;
  logic [2:0] w_live_code, w_play_code;
  logic [1:0] w_rec, w_enter_rec, w_wr;
  logic [3:0] w_base [2];
  logic [2:0] w_trk_code [2];

  // Mode 11 falls through to the live/play decision like mode 00.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = ST_LIVE;
    case (mode)
      2'b01:   w_state_nxt = ST_REC1;
      2'b10:   w_state_nxt = ST_REC2;
      default: if (play != 2'b00) w_state_nxt = ST_PLAY;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) r_state <= ST_LIVE;
    else         r_state <= w_state_nxt;
  end

  assign w_enter_play = (w_state_nxt == ST_PLAY) && (r_state != ST_PLAY);
  assign w_rec        = {w_state_nxt == ST_REC2, w_state_nxt == ST_REC1};
  assign w_enter_rec  = w_rec & {r_state != ST_REC2, r_state != ST_REC1};

  always_comb begin
    w_key_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (keys[i]) w_key_idx = 4'(NUM_KEYS - 1 - i);
  end

  assign w_one_hot   = (keys != '0) && ((keys & (keys - 9'd1)) == '0);
  assign w_live_code = w_one_hot ? key_to_code(w_key_idx) : CODE_REST;
  assign w_event     = w_one_hot && (keys != r_keys_prev);

  // Recording is judged against the state being entered, so an event on the
  // entry edge lands at position 0 of the freshly emptied track.
  always_comb begin
    w_wr = '0;
    for (int t = 0; t < 2; t++) begin
      w_base[t] = w_enter_rec[t] ? 4'd0 : r_len[t];
      w_wr[t]   = resetn && !clear && w_rec[t] && w_event && (w_base[t] < FULL_LEN);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn || clear) begin
      for (int t = 0; t < 2; t++) r_len[t] <= '0;
    end else begin
      for (int t = 0; t < 2; t++)
        if (w_rec[t]) r_len[t] <= w_wr[t] ? w_base[t] + 4'd1 : w_base[t];
    end
  end

  // NOTE: track memories carry no reset; a zero length already hides stale content.
  always_ff @(posedge CLOCK_50) begin
    for (int t = 0; t < 2; t++)
      if (w_wr[t]) r_mem[t][w_base[t]] <= w_key_idx;
  end

  always_comb begin
    w_bound = '0;
    for (int t = 0; t < 2; t++)
      if (r_play[t] && (r_len[t] > w_bound)) w_bound = r_len[t];
    w_step_nxt = r_step;
    if (w_tick)
      w_step_nxt = (({1'b0, r_step} + 5'd1) >= {1'b0, w_bound}) ? 4'd0 : r_step + 4'd1;
    for (int t = 0; t < 2; t++)
      w_trk_code[t] = (r_play[t] && (r_len[t] > w_step_nxt))
                      ? key_to_code(r_mem[t][w_step_nxt]) : CODE_REST;
    w_play_code = (w_trk_code[0] != CODE_REST) ? w_trk_code[0] : w_trk_code[1];
  end

  tempo_tick #(.TICK_DIV(TICK_DIV)) u_tempo_tick (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .i_restart (w_enter_play),
    .i_en      (r_state == ST_PLAY),
    .o_tick    (w_tick)
  );

  // In PLAY the output only moves on the first cycle and on each step.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_keys_prev  <= '0;
      r_play       <= '0;
      r_play_start <= 1'b0;
      r_step       <= '0;
      r_code       <= CODE_REST;
    end else begin
      r_keys_prev  <= keys;
      r_play       <= play;
      r_play_start <= w_enter_play;
      if (w_enter_play)             r_step <= '0;
      else if (r_state == ST_PLAY)  r_step <= w_step_nxt;
      if (r_state != ST_PLAY)           r_code <= w_live_code;
      else if (r_play_start || w_tick)  r_code <= w_play_code;
    end
  end

  assign out_code = r_code;
  assign state_o  = r_state;
  assign rec_full = {r_len[1] == FULL_LEN, r_len[0] == FULL_LEN};
  assign step_idx = r_step;

endmodule

// File: tb/tb_sampler_sequencer.sv
// Directed bench for sampler_sequencer with a short tempo (TICK_DIV = 4).
// Inputs change and outputs are sampled just after each falling edge.
module tb_sampler_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [8:0] keys;
  logic [1:0] mode;
  logic [1:0] play;
  logic       clear;
  logic [2:0] out_code;
  logic [1:0] state_o;
  logic [1:0] rec_full;
  logic [3:0] step_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_code [9] = '{3'b001, 3'b010, 3'b100, 3'b110,
                               3'b011, 3'b011, 3'b011, 3'b011, 3'b011};
  logic [2:0] seq_code [4];
  logic [3:0] seq_step [4];

  always #5 clk = ~clk;

  sampler_sequencer #(.STEPS(9), .TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .keys     (keys),
    .mode     (mode),
    .play     (play),
    .clear    (clear),
    .out_code (out_code),
    .state_o  (state_o),
    .rec_full (rec_full),
    .step_idx (step_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold one key for three cycles, then release for one.
  task automatic press(input int idx);
    keys = 9'h100 >> idx;
    cycles(1);
    check("rec_echo", 32'(out_code), 32'(exp_code[idx]));
    cycles(2);
    keys = '0;
    cycles(1);
  endtask

  // Called one cycle after PLAY entry; each step's note must hold 4 cycles.
  task automatic run_seq(input string tag);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_code_first"}, 32'(out_code), 32'(seq_code[k]));
      check({tag, "_step"}, 32'(step_idx), 32'(seq_step[k]));
      cycles(3);
      check({tag, "_code_last"}, 32'(out_code), 32'(seq_code[k]));
      cycles(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; keys = '0; mode = 2'b00; play = 2'b00; clear = 1'b0;
    cycles(3);
    check("reset_out_code", 32'(out_code), 32'h0);
    check("reset_state",    32'(state_o),  32'h0);
    check("reset_rec_full", 32'(rec_full), 32'h0);
    check("reset_step_idx", 32'(step_idx), 32'h0);
    resetn = 1'b1;
    cycles(1);

    // Live path
    keys = 9'b100000000; cycles(1);
    check("live_q", 32'(out_code), 32'h1);
    keys = 9'b110000000; cycles(1);
    check("live_two_keys", 32'(out_code), 32'h0);
    keys = 9'b000010000; cycles(1);
    check("live_t", 32'(out_code), 32'h3);
    mode = 2'b11; keys = 9'b000000001; cycles(1);
    check("mode11_state", 32'(state_o), 32'h0);
    check("mode11_live_o", 32'(out_code), 32'h3);
    mode = 2'b00; keys = '0; cycles(1);

    // Record track 1 up to and past full
    mode = 2'b01; cycles(1);
    check("rec1_state", 32'(state_o), 32'h1);
    press(0); press(1); press(2);
    check("rec1_len3_not_full", 32'(rec_full), 32'h0);
    for (int i = 3; i < 8; i++) press(i);
    check("rec1_len8_not_full", 32'(rec_full), 32'h0);
    keys = 9'h100; cycles(1);
    check("rec1_full_next_cycle", 32'(rec_full), 32'h1);
    cycles(2); keys = '0; cycles(1);
    press(4); press(5); press(6);
    check("rec1_full_stays", 32'(rec_full), 32'h1);

    // Re-entry empties the track; clear beats a coincident key event
    mode = 2'b00; cycles(1);
    mode = 2'b01; cycles(1);
    check("rec1_reentry_empty", 32'(rec_full), 32'h0);
    for (int i = 0; i < 8; i++) press(i);
    keys = 9'h001; clear = 1'b1; cycles(1);
    clear = 1'b0;
    check("clear_beats_event", 32'(rec_full), 32'h0);
    cycles(2); keys = '0; cycles(1);

    // Track 1 = {q,w,e}, single-track playback
    mode = 2'b00; cycles(1);
    mode = 2'b01; cycles(1);
    press(0); press(1); press(2);
    mode = 2'b00; play = 2'b01; cycles(1);
    check("play1_state", 32'(state_o), 32'h3);
    check("play1_entry_step", 32'(step_idx), 32'h0);
    cycles(1);
    seq_code = '{3'b001, 3'b010, 3'b100, 3'b001};
    seq_step = '{4'd0, 4'd1, 4'd2, 4'd0};
    run_seq("play1");
    check("play1_step_before_leave", 32'(step_idx), 32'h1);
    play = 2'b00; cycles(1);
    check("leave_play_state", 32'(state_o), 32'h0);
    cycles(6);
    check("leave_play_step_hold", 32'(step_idx), 32'h1);

    // Track 1 = {q}, track 2 = {r,t}, both playing
    mode = 2'b01; cycles(1);
    press(0);
    mode = 2'b10; cycles(1);
    check("rec2_state", 32'(state_o), 32'h2);
    press(3); press(4);
    mode = 2'b00; play = 2'b11; cycles(1);
    check("play2_entry_step", 32'(step_idx), 32'h0);
    cycles(1);
    seq_code = '{3'b001, 3'b011, 3'b001, 3'b011};
    seq_step = '{4'd0, 4'd1, 4'd0, 4'd1};
    run_seq("arb");

    // Clear during playback: rest from the next step on
    clear = 1'b1; cycles(1);
    clear = 1'b0; cycles(3);
    check("clear_play_rest", 32'(out_code), 32'h0);
    check("clear_rec_full", 32'(rec_full), 32'h0);
    play = 2'b00; cycles(1);

    // Fill track 2, then re-enter REC2
    mode = 2'b10; cycles(1);
    for (int i = 0; i < 9; i++) press(i);
    check("rec2_full", 32'(rec_full), 32'h2);
    mode = 2'b00; cycles(1);
    mode = 2'b10; cycles(1);
    check("rec2_reentry_empty", 32'(rec_full), 32'h0);

    // Reset in the middle of recording
    mode = 2'b01; cycles(1);
    for (int i = 0; i < 5; i++) press(i);
    keys = 9'h080; cycles(1);
    check("pre_reset_echo", 32'(out_code), 32'h2);
    resetn = 1'b0; mode = 2'b00; cycles(1);
    check("midreset_out_code", 32'(out_code), 32'h0);
    check("midreset_state", 32'(state_o), 32'h0);
    check("midreset_rec_full", 32'(rec_full), 32'h0);
    check("midreset_step_idx", 32'(step_idx), 32'h0);
    resetn = 1'b1; keys = '0; play = 2'b01; cycles(2);
    check("post_reset_track_empty", 32'(out_code), 32'h0);
    cycles(4);
    check("post_reset_track_empty_step", 32'(out_code), 32'h0);
    play = 2'b00; cycles(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
